// File: rtl/uart_cfg_core.sv
// Full-duplex UART with configurable data width, parity and stop bits.
// TX and RX share one 16x tick divider but are otherwise independent.
`timescale 1ns/1ps
module uart_cfg_core #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 start_tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int         DIV_RAW    = CLOCK_FREQ / (BAUD_RATE * 16);
    localparam int         DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int         DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [4:0] STOP_LAST  = 5'(STOP_BITS * 16 - 1);
    localparam logic [3:0] BIT_LAST   = 4'(DATA_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        parity_of = (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ---------------- tick divider ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state, w_tx_next;
    logic [4:0]           r_tx_tick_cnt;
    logic [3:0]           r_tx_bit_cnt;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx, r_tx_busy, r_tx_done;
    logic                 w_tx_accept, w_tx_bit_end;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_tx_next    = r_tx_state;
        w_tx_accept  = 1'b0;
        w_tx_bit_end = w_tick && (r_tx_tick_cnt == ((r_tx_state == TX_STOP) ? STOP_LAST : 5'd15));
        case (r_tx_state)
            TX_IDLE: begin
                if (start_tx) begin
                    w_tx_accept = 1'b1;
                    w_tx_next   = TX_START;
                end
            end
            TX_START:  if (w_tx_bit_end) w_tx_next = TX_DATA;
            TX_DATA: begin
                if (w_tx_bit_end && r_tx_bit_cnt == BIT_LAST)
                    w_tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (w_tx_bit_end) w_tx_next = TX_STOP;
            TX_STOP:   if (w_tx_bit_end) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_tick_cnt <= '0;
            r_tx_bit_cnt  <= '0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_tx          <= 1'b1;
            r_tx_busy     <= 1'b0;
            r_tx_done     <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (w_tx_accept) begin
                r_tx_shift    <= tx_data_in;
                r_tx_par      <= parity_of(tx_data_in);
                r_tx          <= 1'b0;
                r_tx_busy     <= 1'b1;
                r_tx_tick_cnt <= '0;
                r_tx_bit_cnt  <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_bit_end)  r_tx_tick_cnt <= '0;
                else if (w_tick)   r_tx_tick_cnt <= r_tx_tick_cnt + 5'd1;
                // The shifter always presents the next bit to send in bit 0.
                if (w_tx_bit_end) begin
                    case (r_tx_state)
                        TX_START: begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                        TX_DATA: begin
                            r_tx_bit_cnt <= r_tx_bit_cnt + 4'd1;
                            if (r_tx_bit_cnt == BIT_LAST) begin
                                r_tx <= HAS_PARITY ? r_tx_par : 1'b1;
                            end else begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                            end
                        end
                        TX_PARITY: r_tx <= 1'b1;
                        TX_STOP: begin
                            r_tx_done <= 1'b1;
                            r_tx_busy <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;
    assign tx_done = r_tx_done;

    // ---------------- receiver ----------------
    rx_state_t            r_rx_state, w_rx_next;
    logic [1:0]           r_rx_sync;
    logic [3:0]           r_rx_tick_cnt;
    logic [3:0]           r_rx_bit_cnt;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_rx_done, r_parity_err, r_frame_err, r_overrun_err;
    logic                 w_rx_line, w_rx_sample, w_rx_complete;

    assign w_rx_line   = r_rx_sync[1];
    assign w_rx_sample = w_tick && (r_rx_tick_cnt == ((r_rx_state == RX_START) ? 4'd7 : 4'd15));

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_complete = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (!w_rx_line) w_rx_next = RX_START;
            RX_START: if (w_rx_sample) w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (w_rx_sample && r_rx_bit_cnt == BIT_LAST)
                    w_rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (w_rx_sample) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_complete = 1'b1;
                    w_rx_next     = w_rx_line ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: if (w_rx_line) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchroniser resets to the idle-high level so reset release is not a start edge.
            r_rx_sync     <= 2'b11;
            r_rx_tick_cnt <= '0;
            r_rx_bit_cnt  <= '0;
            r_rx_shift    <= '0;
            r_rx_par_bit  <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_done     <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
            r_rx_done <= 1'b0;

            if (r_rx_state == RX_IDLE || r_rx_state == RX_BREAK) begin
                r_rx_tick_cnt <= '0;
                r_rx_bit_cnt  <= '0;
            end else if (w_rx_sample) begin
                r_rx_tick_cnt <= '0;
            end else if (w_tick) begin
                r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            end

            if (r_rx_state == RX_DATA && w_rx_sample) begin
                r_rx_shift   <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
                r_rx_bit_cnt <= r_rx_bit_cnt + 4'd1;
            end
            if (r_rx_state == RX_PARITY && w_rx_sample)
                r_rx_par_bit <= w_rx_line;

            // An ack in the completion cycle consumes the old word, so no overrun.
            if (w_rx_complete) begin
                r_rx_data     <= r_rx_shift;
                r_parity_err  <= HAS_PARITY && (r_rx_par_bit != parity_of(r_rx_shift));
                r_frame_err   <= !w_rx_line;
                r_rx_done     <= 1'b1;
                r_rx_valid    <= 1'b1;
                r_overrun_err <= !rx_ack && (r_rx_valid || r_overrun_err);
            end else if (rx_ack && r_rx_valid) begin
                r_rx_valid    <= 1'b0;
                r_overrun_err <= 1'b0;
            end
        end
    end

    assign rx_data_out = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_done     = r_rx_done;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed bench: instance A is 8E1 (loopback or driven rx), instance B is 8O2 in loopback.
// Both run at 16 MHz / 500 kbaud, i.e. DIV=2 and 32 clocks per bit.
`timescale 1ns/1ps
module tb_uart_cfg_core;

    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 500000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: even parity, one stop bit
    logic [7:0] tx_data_a = '0;
    logic       start_a = 1'b0, ack_a = 1'b0, loop_a = 1'b1, rx_drv = 1'b1;
    logic       busy_a, done_a, tx_a, valid_a, rxdone_a, perr_a, ferr_a, oerr_a;
    logic [7:0] rxd_a;
    logic       rx_a;
    assign rx_a = loop_a ? tx_a : rx_drv;

    // instance B: odd parity, two stop bits, permanent loopback
    logic [7:0] tx_data_b = '0;
    logic       start_b = 1'b0, ack_b = 1'b0;
    logic       busy_b, done_b, tx_b, valid_b, rxdone_b, perr_b, ferr_b, oerr_b;
    logic [7:0] rxd_b;

    uart_cfg_core #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .tx_data_in(tx_data_a), .start_tx(start_a),
        .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a), .rx(rx_a),
        .rx_data_out(rxd_a), .rx_valid(valid_a), .rx_ack(ack_a), .rx_done(rxdone_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(oerr_a));

    uart_cfg_core #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .tx_data_in(tx_data_b), .start_tx(start_b),
        .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b), .rx(tx_b),
        .rx_data_out(rxd_b), .rx_valid(valid_b), .rx_ack(ack_b), .rx_done(rxdone_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(oerr_b));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ndone_a  = 0, ndone_b = 0, done_cyc_a = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rxdone_a) begin
            ndone_a++;
            done_cyc_a = cyc;
        end
        if (rxdone_b) ndone_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Free-running divider: the first tick lands 1..2 clocks after accept, so a
    // frame of N ticks may end one clock before its nominal length.
    function automatic int norm_len(input int cycles, input int nominal);
        norm_len = (cycles == nominal - 1) ? nominal : cycles;
    endfunction

    // Sends one word; samples tx mid-bit into frame[k]; optionally pokes start_tx at poke_at.
    task automatic run_tx(input string tag, input bit use_b, input logic [7:0] data, input int poke_at,
                          output int cycles, output logic [11:0] frame, output logic done_at_end);
        int k;
        @(negedge clk);
        if (use_b) begin tx_data_b = data; start_b = 1'b1; end
        else       begin tx_data_a = data; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, "_accept_busy"}, use_b ? busy_b : busy_a, 1);
        check({tag, "_accept_tx_low"}, use_b ? tx_b : tx_a, 0);
        cycles = 0;
        frame  = '0;
        while ((use_b ? busy_b : busy_a) && cycles < 1000) begin
            @(posedge clk); #1;
            cycles++;
            if (poke_at > 0) begin
                if (cycles == poke_at) begin
                    tx_data_b = 8'hFF; tx_data_a = 8'hFF;
                    if (use_b) start_b = 1'b1; else start_a = 1'b1;
                end else begin
                    start_a = 1'b0; start_b = 1'b0;
                end
            end
            if (cycles >= 16 && (cycles - 16) % 32 == 0) begin
                k = (cycles - 16) / 32;
                if (k < 12) frame[k] = use_b ? tx_b : tx_a;
            end
        end
        done_at_end = use_b ? done_b : done_a;
    endtask

    // Drives one frame on instance A's rx pin, then 64 idle-high clocks.
    task automatic drive_rx(input logic [7:0] d, input logic par, input logic stop_lvl,
                            input int extra_low_bits, output int start_cyc);
        @(negedge clk);
        start_cyc = cyc;
        rx_drv = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (32) @(negedge clk);
        end
        rx_drv = par;
        repeat (32) @(negedge clk);
        rx_drv = stop_lvl;
        repeat (32 * (1 + extra_low_bits)) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic ack_pulse_a();
        @(negedge clk);
        ack_a = 1'b1;
        @(posedge clk); #1;
        ack_a = 1'b0;
    endtask

    int          len, s1, s2, e2, lat, n0;
    logic [11:0] frame;
    logic        done_end;

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_tx_high", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_outputs", {done_a, valid_a, rxdone_a, perr_a, ferr_a, oerr_a}, 0);
        check("rst_rx_data", rxd_a, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // ---- 1: loopback 0xA5, even parity, one stop ----
        loop_a = 1'b1;
        n0 = ndone_a;
        run_tx("t1", 1'b0, 8'hA5, 0, len, frame, done_end);
        check("t1_busy_len", norm_len(len, 352), 352);
        check("t1_done_pulse", done_end, 1);
        check("t1_frame", frame, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
        @(posedge clk); #1;
        check("t1_done_one_cycle", done_a, 0);
        repeat (8) @(posedge clk); #1;
        check("t1_rx_data", rxd_a, 8'hA5);
        check("t1_rx_valid", valid_a, 1);
        check("t1_errs", {perr_a, ferr_a}, 0);
        check("t1_rx_done_count", ndone_a - n0, 1);

        // ---- 2: instance B, odd parity, two stops, start_tx poked mid-frame ----
        run_tx("t2", 1'b1, 8'h01, 100, len, frame, done_end);
        check("t2_busy_len", norm_len(len, 384), 384);
        check("t2_done_pulse", done_end, 1);
        check("t2_frame", frame, {2'b11, 1'b0, 8'h01, 1'b0});
        repeat (40) @(posedge clk); #1;
        check("t2_poke_not_queued", {busy_b, tx_b}, 2'b01);
        check("t2_rx_data", rxd_b, 8'h01);
        check("t2_rx_flags", {valid_b, perr_b, ferr_b}, 3'b100);
        check("t2_rx_done_count", ndone_b, 1);

        // ---- 3: driven rx, bad then good parity ----
        loop_a = 1'b0;
        ack_pulse_a();
        drive_rx(8'h3C, 1'b1, 1'b1, 0, s1);
        check("t3_bad_par_data", rxd_a, 8'h3C);
        check("t3_bad_par_flags", {perr_a, ferr_a}, 2'b10);
        drive_rx(8'h3C, 1'b0, 1'b1, 0, s1);
        check("t3_good_par_flags", {perr_a, ferr_a}, 2'b00);

        // ---- 4: stop bit low, line held low, then a clean frame ----
        ack_pulse_a();
        n0 = ndone_a;
        drive_rx(8'h55, 1'b0, 1'b0, 5, s1);
        check("t4_break_data", rxd_a, 8'h55);
        check("t4_frame_err", ferr_a, 1);
        check("t4_single_done", ndone_a - n0, 1);
        drive_rx(8'h12, 1'b0, 1'b1, 0, s1);
        check("t4_next_data", rxd_a, 8'h12);
        check("t4_next_flags", {perr_a, ferr_a}, 2'b00);
        check("t4_next_done", ndone_a - n0, 2);

        // ---- 5a: back-to-back loopback without ack -> overrun ----
        ack_pulse_a();
        loop_a = 1'b1;
        run_tx("t5a", 1'b0, 8'h11, 0, len, frame, done_end);
        run_tx("t5b", 1'b0, 8'h22, 0, len, frame, done_end);
        repeat (8) @(posedge clk); #1;
        check("t5_ovr_data", rxd_a, 8'h22);
        check("t5_ovr_flags", {valid_a, oerr_a}, 2'b11);
        ack_pulse_a();
        check("t5_ack_clears", {valid_a, oerr_a}, 2'b00);

        // ---- 5b: ack exactly in the completion cycle -> no overrun ----
        loop_a = 1'b0;
        drive_rx(8'h33, 1'b0, 1'b1, 0, s1);
        lat = done_cyc_a - s1;
        check("t5_first_valid", {valid_a, oerr_a}, 2'b10);
        // Same divider phase as the first frame gives the same completion latency.
        while (((cyc + 1) - s1) % 2 != 0) @(negedge clk);
        s2 = cyc + 1;
        e2 = s2 + lat;
        fork
            drive_rx(8'h44, 1'b0, 1'b1, 0, s1);
            begin
                while (cyc < e2 - 1) begin @(posedge clk); #1; end
                ack_a = 1'b1;
                @(posedge clk); #1;
                ack_a = 1'b0;
            end
        join
        check("t5_same_cycle_lat", done_cyc_a, e2);
        check("t5_same_cycle_data", rxd_a, 8'h44);
        check("t5_same_cycle_flags", {valid_a, oerr_a}, 2'b10);

        // ---- 6a: short low glitch is a false start ----
        ack_pulse_a();
        n0 = ndone_a;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (96) @(negedge clk);
        check("t6_glitch_no_done", ndone_a - n0, 0);
        check("t6_glitch_no_valid", {valid_a, perr_a, ferr_a}, 0);

        // ---- 6b: reset mid-transmit, then a clean frame ----
        loop_a = 1'b1;
        @(negedge clk);
        tx_data_a = 8'hFF;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_tx_high", tx_a, 1);
        check("t6_rst_busy_low", busy_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n0 = ndone_a;
        run_tx("t6", 1'b0, 8'h5A, 0, len, frame, done_end);
        check("t6_frame", frame, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0});
        repeat (8) @(posedge clk); #1;
        check("t6_rx_data", rxd_a, 8'h5A);
        check("t6_rx_flags", {valid_a, perr_a, ferr_a, oerr_a}, 4'b1000);
        check("t6_rx_done_count", ndone_a - n0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
